ram2_be_clr: RTL



---
 rtl/ram2_be_clr_pkg.sv | 25 ++
 rtl/ram2_be_clr_if.sv | 35 +++
 rtl/ram2_be_clr_core.sv | 48 ++++
 rtl/ram2_be_clr.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ram2_be_clr_pkg.sv
// Shared types and helpers for the byte-enabled, self-clearing dual-port RAM.
package ram2_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram2_state_t;

    // Widest byte-enable vector the merge helper handles (1024-bit words).
    localparam int unsigned MAX_NB = 128;

    function automatic int unsigned calc_nb(input int unsigned dwidth);
        return dwidth / 8;
    endfunction

    // Port B byte enables after port A claims every byte it also writes at the same address.
    function automatic logic [MAX_NB-1:0] merge_mask_b(
        input logic [MAX_NB-1:0] be_a,
        input logic [MAX_NB-1:0] be_b,
        input logic              same_addr
    );
        return same_addr ? (be_b & ~be_a) : be_b;
    endfunction

endpackage

// File: rtl/ram2_be_clr_if.sv
// User-side bus of ram2_be_clr: clear request/ready, two byte-enabled ports, strobes.
interface ram2_be_clr_if
    import ram2_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 7
);
    localparam int unsigned NB = calc_nb(DWIDTH);

    logic              clr_req;
    logic              ready;
    logic [NB-1:0]     wea;
    logic [NB-1:0]     web;
    logic [AWIDTH-1:0] addra;
    logic [AWIDTH-1:0] addrb;
    logic [DWIDTH-1:0] dia;
    logic [DWIDTH-1:0] dib;
    logic              rena;
    logic              renb;
    logic [DWIDTH-1:0] doa;
    logic [DWIDTH-1:0] dob;
    logic              vala;
    logic              valb;
    logic              wcoll;

    modport master (
        output clr_req, wea, web, addra, addrb, dia, dib, rena, renb,
        input  ready, doa, dob, vala, valb, wcoll
    );

    modport slave (
        input  clr_req, wea, web, addra, addrb, dia, dib, rena, renb,
        output ready, doa, dob, vala, valb, wcoll
    );
endinterface

// File: rtl/ram2_be_clr_core.sv
// Storage array with two read-first, byte-enabled ports; the array itself is never reset.
module ram2_be_core
    import ram2_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 7,
    parameter string       RAM_TYPE = "block",
    localparam int unsigned NB      = calc_nb(DWIDTH),
    localparam int unsigned DEPTH   = 1 << AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NB-1:0]     wea,
    input  logic [NB-1:0]     web,
    input  logic [AWIDTH-1:0] addra,
    input  logic [AWIDTH-1:0] addrb,
    input  logic [DWIDTH-1:0] dia,
    input  logic [DWIDTH-1:0] dib,
    input  logic              rena,
    input  logic              renb,
    output logic [DWIDTH-1:0] doa,
    output logic [DWIDTH-1:0] dob
);
    if ((DWIDTH % 8) != 0 || DWIDTH == 0 || AWIDTH == 0 || RAM_TYPE == "") begin : g_bad_params
        $error("ram2_be_core: unsupported parameter set");
    end

    (* ram_style = RAM_TYPE *) logic [DWIDTH-1:0] mem [DEPTH];

    // Callers guarantee the two ports never write the same byte of the same word.
    always_ff @(posedge clk) begin : p_write
        for (int unsigned i = 0; i < NB; i++) begin
            if (wea[i]) mem[addra][i*8 +: 8] <= dia[i*8 +: 8];
            if (web[i]) mem[addrb][i*8 +: 8] <= dib[i*8 +: 8];
        end
    end

    // Non-blocking reads sample the pre-write word, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin : p_read
        if (!rst_n) begin
            doa <= '0;
            dob <= '0;
        end else begin
            if (rena) doa <= mem[addra];
            if (renb) dob <= mem[addrb];
        end
    end
endmodule

// File: rtl/ram2_be_clr.sv
// Dual-port byte-enabled RAM that fills itself with CLEAR_VALUE after reset or on request.
module ram2_be_clr
    import ram2_pkg::*;
#(
    parameter int unsigned       DWIDTH      = 32,
    parameter int unsigned       AWIDTH      = 7,
    parameter string             RAM_TYPE    = "block",
    parameter int unsigned       OUT_REG     = 0,
    parameter logic [DWIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    ram2_be_clr_if.slave  bus
);
    localparam int unsigned       NB       = calc_nb(DWIDTH);
    localparam logic [AWIDTH-1:0] LAST_PTR = AWIDTH'((1 << AWIDTH) - 2);

    ram2_state_t       state_q, state_d;
    logic [AWIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic              ready_q, wcoll_q, wcoll_d;
    logic              vala_s1, valb_s1;
    logic [DWIDTH-1:0] doa_s1, dob_s1;

    logic              same_addr;
    logic [NB-1:0]     core_wea, core_web;
    logic [AWIDTH-1:0] core_addra, core_addrb;
    logic [DWIDTH-1:0] core_dia, core_dib;
    logic              core_rena, core_renb;

    // Next state and core port mux: clear sweep or user traffic.
    always_comb begin : p_next
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        wcoll_d    = 1'b0;
        core_wea   = '0;
        core_web   = '0;
        core_addra = bus.addra;
        core_addrb = bus.addrb;
        core_dia   = bus.dia;
        core_dib   = bus.dib;
        core_rena  = 1'b0;
        core_renb  = 1'b0;
        same_addr  = (bus.addra == bus.addrb);

        case (state_q)
            ST_CLEAR: begin
                core_wea   = '1;
                core_web   = '1;
                core_addra = clr_ptr_q;
                core_addrb = clr_ptr_q | AWIDTH'(1);
                core_dia   = CLEAR_VALUE;
                core_dib   = CLEAR_VALUE;
                clr_ptr_d  = clr_ptr_q + AWIDTH'(2);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = ST_READY;
                    clr_ptr_d = '0;
                end
            end
            ST_READY: begin
                core_wea  = bus.wea;
                core_web  = NB'(merge_mask_b(MAX_NB'(bus.wea), MAX_NB'(bus.web), same_addr));
                core_rena = bus.rena;
                core_renb = bus.renb;
                wcoll_d   = same_addr && ((bus.wea & bus.web) != '0);
                if (bus.clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
            wcoll_q   <= 1'b0;
            vala_s1   <= 1'b0;
            valb_s1   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= (state_d == ST_READY);
            wcoll_q   <= wcoll_d;
            vala_s1   <= core_rena;
            valb_s1   <= core_renb;
        end
    end

    ram2_be_core #(
        .DWIDTH   (DWIDTH),
        .AWIDTH   (AWIDTH),
        .RAM_TYPE (RAM_TYPE)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .wea   (core_wea),
        .web   (core_web),
        .addra (core_addra),
        .addrb (core_addrb),
        .dia   (core_dia),
        .dib   (core_dib),
        .rena  (core_rena),
        .renb  (core_renb),
        .doa   (doa_s1),
        .dob   (dob_s1)
    );

    if (OUT_REG != 0) begin : g_out_reg
        logic [DWIDTH-1:0] doa_q2, dob_q2;
        logic              vala_q2, valb_q2;

        // Extra stage keeps draining reads even after a clear starts.
        always_ff @(posedge clk or negedge rst_n) begin : p_out
            if (!rst_n) begin
                doa_q2  <= '0;
                dob_q2  <= '0;
                vala_q2 <= 1'b0;
                valb_q2 <= 1'b0;
            end else begin
                vala_q2 <= vala_s1;
                valb_q2 <= valb_s1;
                if (vala_s1) doa_q2 <= doa_s1;
                if (valb_s1) dob_q2 <= dob_s1;
            end
        end

        assign bus.doa  = doa_q2;
        assign bus.dob  = dob_q2;
        assign bus.vala = vala_q2;
        assign bus.valb = valb_q2;
    end else begin : g_no_out_reg
        assign bus.doa  = doa_s1;
        assign bus.dob  = dob_s1;
        assign bus.vala = vala_s1;
        assign bus.valb = valb_s1;
    end

    assign bus.ready = ready_q;
    assign bus.wcoll = wcoll_q;
endmodule
